bin2bcd_seq: RTL and testbench

- Iterative (shift-and-add-3) binary-to-BCD converter.
- Sits directly upstream of the per-digit BCD-to-7-segment decoders: each 4-bit slice of `bcd` drives one decoder.
- Converts one captured binary value per request and holds the digits stable between conversions.
- Supports optional leading-zero blanking and overflow blanking, both using code 4'hF, which the decoders display as all segments off.

---
 rtl/bin2bcd_if.sv | 28 ++
 rtl/bin2bcd_seq.sv | 143 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bin2bcd_if.sv
// Handshake/data bundle between a requester and the bin2bcd_seq converter.
//   start : conversion request (requester -> converter)
//   bin   : binary value to convert (requester -> converter)
//   busy  : conversion in progress (converter -> requester)
//   done  : one-cycle result-valid pulse (converter -> requester)
//   ovf   : last converted value did not fit in DIGITS digits
//   bcd   : packed BCD digits, digit 0 in [3:0]
interface bin2bcd_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                start;
    logic [BIN_W-1:0]    bin;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [4*DIGITS-1:0] bcd;

    modport master (
        output start, bin,
        input  busy, done, ovf, bcd
    );

    modport slave (
        input  start, bin,
        output busy, done, ovf, bcd
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter feeding per-digit
// 7-segment decoders. One conversion per accepted start; digits are held
// stable between conversions. Code 4'hF is used for blanked digits
// (leading zeros when LZB=1, every digit on overflow).
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bin2bcd_if slave (start/bin in; busy/done/ovf/bcd out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; bcd/ovf hold the last result
// SHIFT | BIN_W add-3/shift iterations on the working register
// DONE  | one-cycle result-valid pulse, then back to IDLE
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4,
    parameter int LZB    = 1
) (
    input logic       clk,
    input logic       rst,
    bin2bcd_if.slave  bus
);

    localparam int WW = 4*DIGITS + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = 64'(10**DIGITS) - 64'd1;

    // Reset/idle display of the value 0, honouring leading-zero blanking.
    function automatic logic [4*DIGITS-1:0] zero_bcd();
        logic [4*DIGITS-1:0] r;
        r = '0;
        if (LZB != 0) begin
            for (int i = 1; i < DIGITS; i++) r[4*i +: 4] = 4'hF;
        end
        return r;
    endfunction

    localparam logic [4*DIGITS-1:0] BCD_RST = zero_bcd();

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q;
    logic [WW-1:0]       work_q;
    logic [WW-1:0]       work_d;
    logic [CW-1:0]       cnt_q;
    logic                ovf_pend_q;
    logic                busy_q;
    logic                done_q;
    logic                ovf_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] digits_d;
    logic [4*DIGITS-1:0] bcd_d;
    logic                lead_zero;
    logic [63:0]         bin_ext;
    logic                ovf_cmp;

    assign bin_ext = 64'(bus.bin);
    assign ovf_cmp = (bin_ext > MAX_VAL);

    // One iteration: each digit >= 5 gets +3 (no inter-digit carry), then
    // shift the whole register left. Carries off the top digit are dropped;
    // overflow is flagged from the captured input instead.
    always_comb begin
        work_d = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[BIN_W+4*i +: 4] >= 4'd5)
                work_d[BIN_W+4*i +: 4] = work_q[BIN_W+4*i +: 4] + 4'd3;
        end
        work_d = work_d << 1;
    end

    assign digits_d = work_d[WW-1:BIN_W];

    // Display formatting of the final digit field.
    always_comb begin
        bcd_d     = digits_d;
        lead_zero = 1'b1;
        if (ovf_pend_q) begin
            bcd_d = '1;
        end else if (LZB != 0) begin
            for (int i = DIGITS-1; i >= 1; i--) begin
                if (lead_zero && digits_d[4*i +: 4] == 4'd0)
                    bcd_d[4*i +: 4] = 4'hF;
                else
                    lead_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= BCD_RST;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work_q     <= {{(4*DIGITS){1'b0}}, bus.bin};
                        cnt_q      <= CW'(BIN_W);
                        ovf_pend_q <= ovf_cmp;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= bcd_d;
                        ovf_q   <= ovf_pend_q;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    bin2bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus0 ();
    bin2bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus1 ();

    assign bus1.start = bus0.start;
    assign bus1.bin   = bus0.bin;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .LZB(1)) dut_lzb (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .LZB(0)) dut_nolzb (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by division, then display rules.
    function automatic logic [15:0] model_bcd(input int v, input bit lzb);
        logic [15:0] r;
        bit          lead;
        int          d;
        if (v > 9999) return 16'hFFFF;
        r    = '0;
        lead = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            d = (v / (10**i)) % 10;
            if (lzb && lead && d == 0 && i > 0) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                r[4*i +: 4] = 4'(d);
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the converter idle (or entering IDLE at the
    // next edge). Returns at the negedge of the idle cycle after DONE.
    task automatic do_conv(input int v, input bit hold_start, input bit scramble);
        bus0.start = 1'b1;
        bus0.bin   = 14'(v);
        @(negedge clk);
        if (!hold_start) bus0.start = 1'b0;
        for (int k = 0; k < BIN_W; k++) begin
            chk("busy_lzb", bus0.busy, 1);
            chk("busy_nolzb", bus1.busy, 1);
            chk("done_early", bus0.done, 0);
            if (scramble) bus0.bin = (k == 0) ? 14'd9876 : 14'($urandom);
            if (!hold_start) bus0.start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("done_pulse", bus0.done, 1);
        chk("done_pulse_nolzb", bus1.done, 1);
        chk("busy_in_done", bus0.busy, 0);
        chk("bcd_lzb", bus0.bcd, model_bcd(v, 1'b1));
        chk("bcd_nolzb", bus1.bcd, model_bcd(v, 1'b0));
        chk("ovf", bus0.ovf, (v > 9999) ? 1 : 0);
        chk("ovf_nolzb", bus1.ovf, (v > 9999) ? 1 : 0);
        if (!hold_start) bus0.start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", bus0.done, 0);
        chk("busy_idle", bus0.busy, 0);
        chk("bcd_held", bus0.bcd, model_bcd(v, 1'b1));
    endtask

    initial begin
        bit seen_done;
        int v;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus0.start  = 1'b0;
        bus0.bin    = '0;
        #1;
        chk("rst_busy", bus0.busy, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_ovf", bus0.ovf, 0);
        chk("rst_bcd_lzb", bus0.bcd, 16'hFFF0);
        chk("rst_bcd_nolzb", bus1.bcd, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_conv(1234, 1'b0, 1'b0);
        do_conv(0, 1'b0, 1'b0);
        do_conv(7, 1'b0, 1'b0);
        do_conv(1005, 1'b0, 1'b0);
        do_conv(9999, 1'b0, 1'b0);
        do_conv(10000, 1'b0, 1'b0);
        do_conv(42, 1'b0, 1'b0);

        // start held high: back-to-back conversions every BIN_W+2 cycles
        do_conv(1, 1'b1, 1'b0);
        do_conv(2, 1'b1, 1'b0);
        do_conv(3, 1'b1, 1'b0);
        bus0.start = 1'b0;
        @(negedge clk);

        // bin changes after the accept edge must not matter
        do_conv(1234, 1'b0, 1'b1);

        // reset in the middle of a conversion
        bus0.start = 1'b1;
        bus0.bin   = 14'd4321;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus0.busy, 0);
        chk("abort_done", bus0.done, 0);
        chk("abort_bcd_lzb", bus0.bcd, 16'hFFF0);
        chk("abort_bcd_nolzb", bus1.bcd, 16'h0000);
        chk("abort_ovf", bus0.ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus0.done || bus0.busy) seen_done = 1'b1;
        end
        chk("no_done_after_abort", seen_done, 0);
        do_conv(4321, 1'b0, 1'b0);

        // randomized values across the full input range
        repeat (20) begin
            v = $urandom_range(0, (1 << BIN_W) - 1);
            do_conv(v, 1'b0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
